// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcodes, ALU control encodings, FSM states and opcode decoder
// Revision: 1.0
// ============================================================================
package alu_pkg;

  localparam logic [3:0] OP_ZERO = 4'd0;
  localparam logic [3:0] OP_ONE  = 4'd1;
  localparam logic [3:0] OP_NEG1 = 4'd2;
  localparam logic [3:0] OP_X    = 4'd3;
  localparam logic [3:0] OP_Y    = 4'd4;
  localparam logic [3:0] OP_NOTX = 4'd5;
  localparam logic [3:0] OP_NOTY = 4'd6;
  localparam logic [3:0] OP_NEGX = 4'd7;
  localparam logic [3:0] OP_NEGY = 4'd8;
  localparam logic [3:0] OP_XINC = 4'd9;
  localparam logic [3:0] OP_YINC = 4'd10;
  localparam logic [3:0] OP_XDEC = 4'd11;
  localparam logic [3:0] OP_YDEC = 4'd12;
  localparam logic [3:0] OP_ADD  = 4'd13;
  localparam logic [3:0] OP_SUB  = 4'd14;
  localparam logic [3:0] OP_AND  = 4'd15;

  // Bit order, MSB first: zx nx zy ny f no
  localparam logic [5:0] CTL_ZERO = 6'b101010;
  localparam logic [5:0] CTL_ONE  = 6'b111111;
  localparam logic [5:0] CTL_NEG1 = 6'b111010;
  localparam logic [5:0] CTL_X    = 6'b001100;
  localparam logic [5:0] CTL_Y    = 6'b110000;
  localparam logic [5:0] CTL_NOTX = 6'b001101;
  localparam logic [5:0] CTL_NOTY = 6'b110001;
  localparam logic [5:0] CTL_NEGX = 6'b001111;
  localparam logic [5:0] CTL_NEGY = 6'b110011;
  localparam logic [5:0] CTL_XINC = 6'b011111;
  localparam logic [5:0] CTL_YINC = 6'b110111;
  localparam logic [5:0] CTL_XDEC = 6'b001110;
  localparam logic [5:0] CTL_YDEC = 6'b110010;
  localparam logic [5:0] CTL_ADD  = 6'b000010;
  localparam logic [5:0] CTL_SUB  = 6'b010011;
  localparam logic [5:0] CTL_AND  = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctl_t;

  function automatic alu_ctl_t decode_op(input logic [3:0] op);
    logic [5:0] ctl;
    unique case (op)
      OP_ZERO: ctl = CTL_ZERO;
      OP_ONE:  ctl = CTL_ONE;
      OP_NEG1: ctl = CTL_NEG1;
      OP_X:    ctl = CTL_X;
      OP_Y:    ctl = CTL_Y;
      OP_NOTX: ctl = CTL_NOTX;
      OP_NOTY: ctl = CTL_NOTY;
      OP_NEGX: ctl = CTL_NEGX;
      OP_NEGY: ctl = CTL_NEGY;
      OP_XINC: ctl = CTL_XINC;
      OP_YINC: ctl = CTL_YINC;
      OP_XDEC: ctl = CTL_XDEC;
      OP_YDEC: ctl = CTL_YDEC;
      OP_ADD:  ctl = CTL_ADD;
      OP_SUB:  ctl = CTL_SUB;
      default: ctl = CTL_AND;
    endcase
    return alu_ctl_t'(ctl);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// alu_core : combinational Hack-style ALU, parameterised width
// Revision: 1.0
// ============================================================================
module alu_core #(
  parameter int WIDTH = 4
) (
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] w_x0, w_x1, w_y0, w_y1, w_fn;

  assign w_x0 = zx ? '0 : x;
  assign w_x1 = nx ? ~w_x0 : w_x0;
  assign w_y0 = zy ? '0 : y;
  assign w_y1 = ny ? ~w_y0 : w_y0;
  // Sum wraps modulo 2^WIDTH; carry-out is intentionally dropped.
  assign w_fn = f ? (w_x1 + w_y1) : (w_x1 & w_y1);
  assign out  = no ? ~w_fn : w_fn;

endmodule
`default_nettype wire

// File: rtl/alu_sched.sv
`default_nettype none
// ============================================================================
// alu_sched : round-robin scheduler sharing one ALU between two requesters
// Revision: 1.0
// ============================================================================
module alu_sched #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [7:0]         req_op,
  input  logic [2*WIDTH-1:0] req_x,
  input  logic [2*WIDTH-1:0] req_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_zr,
  output logic               rsp_ng
);

  import alu_pkg::*;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] data_q;
  logic             zr_q, ng_q;

  logic             w_any;
  logic             w_gid;
  logic             w_hs;
  alu_ctl_t         w_ctl;
  logic [WIDTH-1:0] w_alu_out;

  assign w_any = |req_valid;
  // Pointer only breaks ties; a lone requester always wins.
  assign w_gid = (&req_valid) ? ptr_q : req_valid[1];

  always_comb begin
    req_ready = 2'b00;
    if (!rst && (state_q == ST_IDLE) && w_any) begin
      req_ready = w_gid ? 2'b10 : 2'b01;
    end
  end

  assign w_hs = |req_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (w_hs) begin
          state_d = ST_EXEC;
          ptr_d   = ~w_gid;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_ctl = decode_op(op_q);

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .zx  (w_ctl.zx),
    .nx  (w_ctl.nx),
    .zy  (w_ctl.zy),
    .ny  (w_ctl.ny),
    .f   (w_ctl.f),
    .no  (w_ctl.no),
    .x   (x_q),
    .y   (y_q),
    .out (w_alu_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      id_q     <= 1'b0;
      op_q     <= OP_ZERO;
      x_q      <= '0;
      y_q      <= '0;
      rsp_id_q <= 1'b0;
      data_q   <= '0;
      zr_q     <= 1'b0;
      ng_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (w_hs) begin
        id_q <= w_gid;
        op_q <= w_gid ? req_op[7:4] : req_op[3:0];
        x_q  <= w_gid ? req_x[WIDTH +: WIDTH] : req_x[0 +: WIDTH];
        y_q  <= w_gid ? req_y[WIDTH +: WIDTH] : req_y[0 +: WIDTH];
      end
      // Response fields are only written in EXEC, so they stay frozen in RESP.
      if (state_q == ST_EXEC) begin
        rsp_id_q <= id_q;
        data_q   <= w_alu_out;
        zr_q     <= (w_alu_out == '0);
        ng_q     <= w_alu_out[WIDTH-1];
      end
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = data_q;
  assign rsp_zr    = zr_q;
  assign rsp_ng    = ng_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// ============================================================================
// tb_alu_sched : self-checking bench for alu_sched with a behavioural model
// Revision: 1.0
// ============================================================================
module tb_alu_sched;

  localparam int WIDTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [7:0]   req_op;
  logic [7:0]   req_x;
  logic [7:0]   req_y;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [3:0]   rsp_data;
  logic         rsp_zr;
  logic         rsp_ng;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [3:0] op_v [2];
  logic [3:0] x_v  [2];
  logic [3:0] y_v  [2];

  alu_sched #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_zr    (rsp_zr),
    .rsp_ng    (rsp_ng)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] alu_ref(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
    logic [3:0] r;
    case (op)
      4'd0:    r = 4'd0;
      4'd1:    r = 4'd1;
      4'd2:    r = 4'hF;
      4'd3:    r = x;
      4'd4:    r = y;
      4'd5:    r = ~x;
      4'd6:    r = ~y;
      4'd7:    r = 4'd0 - x;
      4'd8:    r = 4'd0 - y;
      4'd9:    r = x + 4'd1;
      4'd10:   r = y + 4'd1;
      4'd11:   r = x - 4'd1;
      4'd12:   r = y - 4'd1;
      4'd13:   r = x + y;
      4'd14:   r = x - y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pack_fields;
    req_op = {op_v[1], op_v[0]};
    req_x  = {x_v[1], x_v[0]};
    req_y  = {y_v[1], y_v[0]};
  endtask

  task automatic rand_fields(input int i);
    op_v[i] = 4'($urandom_range(0, 15));
    x_v[i]  = 4'($urandom_range(0, 15));
    y_v[i]  = 4'($urandom_range(0, 15));
  endtask

  // Issues one request from a single requester and collects its response.
  task automatic send(input int id, input logic [3:0] op, input logic [3:0] x, input logic [3:0] y,
                      output bit ok, output int lat, output logic gid, output logic [3:0] gd,
                      output logic gz, output logic gn);
    ok = 0; lat = 0; gid = 1'b0; gd = 4'd0; gz = 1'b0; gn = 1'b0;
    op_v[id] = op; x_v[id] = x; y_v[id] = y;
    pack_fields();
    req_valid[id] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_ready[id]) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin
      req_valid[id] = 1'b0;
      return;
    end
    tick();
    req_valid[id] = 1'b0;
    ok  = 0;
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (rsp_valid) begin
        ok = 1; gid = rsp_id; gd = rsp_data; gz = rsp_zr; gn = rsp_ng;
        break;
      end
      tick();
      lat++;
    end
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    op_v[0] = 4'd3; x_v[0] = 4'd7; y_v[0] = 4'd0;
    op_v[1] = 4'd4; x_v[1] = 4'd0; y_v[1] = 4'd9;
    pack_fields();
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng} !== 10'd0)
        $display("FAIL reset_outputs: got ready=%b vld=%b id=%b data=%0d zr=%b ng=%b, want all zero",
                 req_ready, rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_grant: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tick();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 4'd7}) begin
      errors++;
      $display("FAIL reset_first_rsp: got vld=%b id=%b data=%0d want vld=1 id=0 data=7",
               rsp_valid, rsp_id, rsp_data);
    end
    tick();
  endtask

  task automatic test_single;
    bit ok; int lat; logic gid, gz, gn; logic [3:0] gd;
    send(0, 4'd13, 4'd5, 4'd3, ok, lat, gid, gd, gz, gn);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: no handshake/response"); end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", lat); end
    checks++;
    if ({gid, gd, gz, gn} !== {1'b0, 4'd8, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_add: got id=%b data=%0d zr=%b ng=%b want id=0 data=8 zr=0 ng=1", gid, gd, gz, gn);
    end
  endtask

  task automatic test_wrap;
    bit ok; int lat; logic gid, gz, gn; logic [3:0] gd;
    send(1, 4'd9, 4'd15, 4'd0, ok, lat, gid, gd, gz, gn);
    checks++;
    if (!ok || {gid, gd, gz, gn} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_inc: got ok=%0d id=%b data=%0d zr=%b ng=%b want id=1 data=0 zr=1 ng=0", ok, gid, gd, gz, gn);
    end
    send(1, 4'd14, 4'd2, 4'd5, ok, lat, gid, gd, gz, gn);
    checks++;
    if (!ok || {gid, gd, gz, gn} !== {1'b1, 4'd13, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_sub: got ok=%0d id=%b data=%0d zr=%b ng=%b want id=1 data=13 zr=0 ng=1", ok, gid, gd, gz, gn);
    end
  endtask

  task automatic test_contention;
    logic       exp_id [$];
    logic [3:0] exp_d  [$];
    int last_g, last_c, ngrant, g;
    last_g = -1; last_c = 0; ngrant = 0;
    rsp_ready = 1'b1;
    rand_fields(0);
    rand_fields(1);
    pack_fields();
    req_valid = 2'b11;
    for (int c = 0; c < 48; c++) begin
      if (c == 42) req_valid = 2'b00;
      #1;
      g = -1;
      if (req_ready != 2'b00) begin
        g = req_ready[1] ? 1 : 0;
        checks++;
        if (req_ready == 2'b11) begin errors++; $display("FAIL cont_onehot: got %b", req_ready); end
        checks++;
        // The previous grant in the run went to requester 1, so requester 0 leads.
        if ((ngrant == 0) ? (g != 0) : (g == last_g)) begin
          errors++;
          $display("FAIL cont_order: got grant %0d after %0d (grant #%0d)", g, last_g, ngrant);
        end
        if (ngrant > 0) begin
          checks++;
          if (cyc - last_c != 3) begin
            errors++;
            $display("FAIL cont_spacing: got %0d cycles want 3", cyc - last_c);
          end
        end
        exp_id.push_back(g[0]);
        exp_d.push_back(alu_ref(op_v[g], x_v[g], y_v[g]));
        last_g = g; last_c = cyc; ngrant++;
      end
      if (rsp_valid) begin
        checks++;
        if (exp_id.size() == 0) begin
          errors++;
          $display("FAIL cont_unexpected_rsp: got id=%b data=%0d with none pending", rsp_id, rsp_data);
        end else begin
          if ({rsp_id, rsp_data, rsp_zr, rsp_ng} !== {exp_id[0], exp_d[0], exp_d[0] == 4'd0, exp_d[0][3]}) begin
            errors++;
            $display("FAIL cont_rsp: got id=%b data=%0d zr=%b ng=%b want id=%b data=%0d",
                     rsp_id, rsp_data, rsp_zr, rsp_ng, exp_id[0], exp_d[0]);
          end
          void'(exp_id.pop_front());
          void'(exp_d.pop_front());
        end
      end
      tick();
      if (g >= 0) begin
        rand_fields(g);
        pack_fields();
      end
    end
    checks++;
    if (ngrant < 12 || exp_id.size() != 0) begin
      errors++;
      $display("FAIL cont_totals: got %0d grants, %0d pending; want >=12 grants, 0 pending", ngrant, exp_id.size());
    end
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    op_v[0] = 4'd15; x_v[0] = 4'd12; y_v[0] = 4'd10;
    op_v[1] = 4'd13; x_v[1] = 4'd1;  y_v[1] = 4'd2;
    pack_fields();
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b11;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, req_ready} !== {1'b1, 1'b0, 4'd8, 1'b0, 1'b1, 2'b00}) begin
        errors++;
        $display("FAIL bp_stall: got vld=%b id=%b data=%0d zr=%b ng=%b ready=%b want vld=1 id=0 data=8 zr=0 ng=1 ready=00",
                 rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_data, req_ready} !== {1'b1, 4'd8, 2'b00}) begin
      errors++;
      $display("FAIL bp_release: got vld=%b data=%0d ready=%b want vld=1 data=8 ready=00", rsp_valid, rsp_data, req_ready);
    end
    tick();
    #1;
    checks++;
    if ({rsp_valid, req_ready} !== {1'b0, 2'b10}) begin
      errors++;
      $display("FAIL bp_next_accept: got vld=%b ready=%b want vld=0 ready=10", rsp_valid, req_ready);
    end
    tick();
    req_valid = 2'b00;
    tick();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 4'd3}) begin
      errors++;
      $display("FAIL bp_second_rsp: got vld=%b id=%b data=%0d want vld=1 id=1 data=3", rsp_valid, rsp_id, rsp_data);
    end
    tick();
  endtask

  task automatic test_reset_midop;
    bit ok; int lat; logic gid, gz, gn; logic [3:0] gd;
    rsp_ready = 1'b1;
    op_v[0] = 4'd7; x_v[0] = 4'd3; y_v[0] = 4'd0;
    pack_fields();
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (req_ready[0]) break;
      tick();
    end
    tick();
    req_valid = 2'b00;
    rst = 1'b1;
    tick();
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng} !== 10'd0) begin
      errors++;
      $display("FAIL midop_reset_vals: got ready=%b vld=%b id=%b data=%0d zr=%b ng=%b want all zero",
               req_ready, rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midop_no_rsp: got rsp_valid=%b want 0", rsp_valid); end
    end
    tick();
    send(1, 4'd11, 4'd0, 4'd6, ok, lat, gid, gd, gz, gn);
    checks++;
    if (!ok || lat != 2 || {gid, gd, gz, gn} !== {1'b1, 4'd15, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midop_recover: got ok=%0d lat=%0d id=%b data=%0d zr=%b ng=%b want lat=2 id=1 data=15 zr=0 ng=1",
               ok, lat, gid, gd, gz, gn);
    end
  endtask

  task automatic test_random;
    logic       q_id [$];
    logic [3:0] q_d  [$];
    int phase, mptr, g;
    logic [1:0] exp_rdy, acc;
    // After the mid-op reset only requester 1 was granted, so the pointer is back at 0.
    phase = 0; mptr = 0; g = 0; acc = 2'b00;
    req_valid = 2'b00;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || !req_valid[i]) begin
          rand_fields(i);
          req_valid[i] = ($urandom_range(0, 1) == 1);
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      pack_fields();
      rsp_ready = ($urandom_range(0, 2) != 0);
      acc = 2'b00;
      #1;
      checks++;
      if (rsp_valid !== (phase == 2)) begin
        errors++;
        $display("FAIL rnd_rsp_valid: cycle %0d got %b want %b", c, rsp_valid, phase == 2);
      end
      if (phase == 2 && q_id.size() > 0) begin
        checks++;
        if ({rsp_id, rsp_data, rsp_zr, rsp_ng} !== {q_id[0], q_d[0], q_d[0] == 4'd0, q_d[0][3]}) begin
          errors++;
          $display("FAIL rnd_rsp: cycle %0d got id=%b data=%0d zr=%b ng=%b want id=%b data=%0d",
                   c, rsp_id, rsp_data, rsp_zr, rsp_ng, q_id[0], q_d[0]);
        end
      end
      exp_rdy = 2'b00;
      if (phase == 0 && req_valid != 2'b00) begin
        g = (req_valid == 2'b11) ? mptr : (req_valid[1] ? 1 : 0);
        exp_rdy[g] = 1'b1;
      end
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rnd_ready: cycle %0d valid=%b got %b want %b", c, req_valid, req_ready, exp_rdy);
      end
      case (phase)
        0: if (exp_rdy != 2'b00) begin
             q_id.push_back(g[0]);
             q_d.push_back(alu_ref(op_v[g], x_v[g], y_v[g]));
             mptr  = 1 - g;
             acc   = exp_rdy;
             phase = 1;
           end
        1: phase = 2;
        default: if (rsp_ready) begin
             void'(q_id.pop_front());
             void'(q_d.pop_front());
             phase = 0;
           end
      endcase
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req_op = 8'd0;
    req_x = 8'd0;
    req_y = 8'd0;
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler and sequencer that shares one 4-bit Hack-style ALU between two requesters. Each requester submits an opcode plus two operands over a valid/ready handshake. The block arbitrates, decodes the opcode into the six ALU control bits (zx, nx, zy, ny, f, no) and runs the operation. It returns the result with zero/negative flags and the requester id over a single response channel. It sits between the instruction front-ends and the shared ALU datapath.

## Interface
- WIDTH, 4, operand/result width in bits
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; at most one bit high
- req_op  in  8  packed opcodes, [4i+3:4i] for requester i
- req_x  in  2*WIDTH  packed x operands, [WIDTH*i +: WIDTH]
- req_y  in  2*WIDTH  packed y operands, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer accept
- rsp_id  out  1  requester index of the response
- rsp_data  out  WIDTH  ALU result
- rsp_zr  out  1  rsp_data == 0
- rsp_ng  out  1  rsp_data[WIDTH-1]

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - if any req_valid, grant one requester.
  - req_ready[g] = (state==IDLE) && grant[g]; this path is combinational from req_valid.
  - on the handshake, latch op/x/y/id and go to EXEC.
- EXEC: the ALU core evaluates the latched controls and operands; register result and flags; go to RESP.
- RESP:
  - hold rsp_valid=1 with stable id/data/flags until rsp_ready=1.
  - on that cycle, drop rsp_valid and return to IDLE.
  - no request is accepted while in RESP.
- Arbitration: round-robin with a 1-bit priority pointer.
  - only one valid: that requester wins regardless of the pointer.
  - both valid: the pointer's requester wins.
  - after each accepted grant, the pointer moves to the other requester.
- Opcode decode (op: zx nx zy ny f no):
  - 0: 0 → 101010; 1: 1 → 111111; 2: -1 → 111010
  - 3: x → 001100; 4: y → 110000
  - 5: !x → 001101; 6: !y → 110001
  - 7: -x → 001111; 8: -y → 110011
  - 9: x+1 → 011111; 10: y+1 → 110111
  - 11: x-1 → 001110; 12: y-1 → 110010
  - 13: x+y → 000010; 14: x-y → 010011; 15: x&y → 000000
- Arithmetic: two's complement, modulo 2^WIDTH; carry-out is discarded and no overflow flag is produced.
- Requests must hold op/x/y stable while valid and not ready. Values are sampled only on the handshake.

## Timing
- Reset values:
  - state=IDLE, pointer=0
  - req_ready=00 (until valid is seen)
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zr=0, rsp_ng=0
- Latency: handshake at cycle N gives rsp_valid=1 at N+2.
- Minimum issue interval is 3 cycles (accept, EXEC, RESP with rsp_ready=1).
- rsp_ready stalled in RESP: outputs frozen, req_ready=00, pointer unchanged.
- req_valid deasserted before being granted: no effect, no latch.
- Reset mid-operation (EXEC or RESP): transaction discarded, no response issued, all outputs return to reset values the next cycle.
- rsp_ready high outside RESP is ignored.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit opcode constants OP_ZERO..OP_AND
  - the 6-bit control constants
  - the FSM state encoding
  - a decode function op → controls
- One sub-module, alu_core: a combinational parameterised ALU with inputs zx, nx, zy, ny, f, no, x, y and output out. alu_sched instantiates it once on the latched controls and operands.
- The scheduler holds the FSM, pointer, latches, result/flag registers and handshake logic.

## Test plan
- Reset: hold rst for 2 cycles with req_valid=11 → req_ready=00 and all rsp_* = 0 during reset; the first grant after release goes to requester 0.
- Single request, requester 0, op=13 (x+y), x=5, y=3 → rsp_valid at N+2 with id=0, data=8, zr=0, ng=1.
- Wrap-around, requester 1:
  - op=9 (x+1), x=15 → data=0, zr=1, ng=0.
  - op=14 (x-y), x=2, y=5 → data=13, ng=1.
- Contention: req_valid=11 continuously with rsp_ready=1 → grants alternate 0,1,0,1 and rsp_id follows the same order. Accepts are spaced exactly 3 cycles apart.
- Backpressure: op=15, x=12, y=10 with rsp_ready=0 for 5 cycles → rsp_data=8 held stable and req_ready=00 throughout. The next accept occurs the cycle after rsp_ready=1 is seen.
- Reset mid-op: assert rst during EXEC → no rsp_valid afterwards. The next request completes normally with a correct result.
